// File: rtl/unshift_origin_pkg.sv
// ---------------------------------------------------------------------------
// unshift_origin_pkg
//
// Purpose:
//   Shared render-pipeline definitions. The screen-centre origin offsets and
//   the screen limits live here so that the forward origin shift and its
//   inverse (unshift_origin) always agree on the same constants.
//
// Contents:
//   ORIGIN_X / ORIGIN_Y : screen-centre offset, 5 fractional bits (320, 240 px)
//   SCR_W / SCR_H       : screen size limits, 5 fractional bits (640, 480 px)
//   NUM_VTX / LAST_IDX  : vertices per quad and index of the final vertex
//   state_e             : two-state emitter FSM encoding
//   vertex_t            : one X/Y/Z vertex, signed 16-bit per coordinate
//   isLastVertex()      : helper that flags the final vertex of a quad
// ---------------------------------------------------------------------------
package unshift_origin_pkg;

    localparam logic [15:0] ORIGIN_X = 16'h2800;
    localparam logic [15:0] ORIGIN_Y = 16'h1e00;
    localparam logic [15:0] SCR_W    = 16'h5000;
    localparam logic [15:0] SCR_H    = 16'h3c00;

    localparam int          NUM_VTX  = 4;
    localparam logic [1:0]  LAST_IDX = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vertex_t;

    function automatic logic isLastVertex(input logic [1:0] idx);
        return (idx == LAST_IDX);
    endfunction

endpackage

// File: rtl/vtx_unshift.sv
// ---------------------------------------------------------------------------
// vtx_unshift
//
// Purpose:
//   Combinational inverse origin shift for one vertex. Moves a screen-space
//   vertex (origin top-left) into centred space by subtracting the origin
//   offsets with plain 16-bit two's complement wrap, so that it exactly
//   undoes the forward shift. Also reports whether the original screen-space
//   position lies inside the visible screen.
//
// Ports:
//   vtx_i      : input  vertex_t  screen-space vertex
//   vtx_o      : output vertex_t  centred-space vertex (Z passes through)
//   onscreen_o : output 1 bit     0 <= X < SCR_W and 0 <= Y < SCR_H (signed)
// ---------------------------------------------------------------------------
module vtx_unshift
    import unshift_origin_pkg::vertex_t;
#(
    parameter logic signed [15:0] ORIGIN_X = unshift_origin_pkg::ORIGIN_X,
    parameter logic signed [15:0] ORIGIN_Y = unshift_origin_pkg::ORIGIN_Y,
    parameter logic signed [15:0] SCR_W    = unshift_origin_pkg::SCR_W,
    parameter logic signed [15:0] SCR_H    = unshift_origin_pkg::SCR_H
)(
    input  vertex_t vtx_i,
    output vertex_t vtx_o,
    output logic    onscreen_o
);

    logic signed [15:0] inX;
    logic signed [15:0] inY;
    logic               xInside;
    logic               yInside;

    assign inX = vtx_i.x;
    assign inY = vtx_i.y;

    // Subtraction deliberately wraps: the forward shift adds the same
    // offsets with wrap, so no saturation is applied here either.
    assign vtx_o.x = inX - ORIGIN_X;
    assign vtx_o.y = inY - ORIGIN_Y;
    assign vtx_o.z = vtx_i.z;

    // Visibility is judged on the screen-space coordinates, before the
    // shift, with the far edges excluded.
    assign xInside    = (inX >= 16'sd0) && (inX < SCR_W);
    assign yInside    = (inY >= 16'sd0) && (inY < SCR_H);
    assign onscreen_o = xInside && yInside;

endmodule

// File: rtl/unshift_origin.sv
// ---------------------------------------------------------------------------
// unshift_origin
//
// Purpose:
//   Accepts a quad of four screen-space vertices in one handshake and emits
//   them one vertex per cycle in centred space (origin offsets removed),
//   tagged with the vertex index, a last flag and an on-screen flag.
//   A new quad can be taken on the cycle the final vertex is consumed, so a
//   steady stream runs at four cycles per quad with no bubbles.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid / in_ready    : quad input handshake
//   vtx1_X .. vtx4_Z       : 12 signed 16-bit screen-space coordinates
//   out_valid / out_ready  : vertex output handshake
//   out_X, out_Y, out_Z    : centred-space coordinates of the current vertex
//   out_idx                : vertex number 0..3 (vtx1..vtx4)
//   out_last               : high on the final vertex of the quad
//   out_onscreen           : the current vertex was inside the screen
// ---------------------------------------------------------------------------
module unshift_origin
    import unshift_origin_pkg::state_e;
    import unshift_origin_pkg::vertex_t;
    import unshift_origin_pkg::IDLE;
    import unshift_origin_pkg::SEND;
    import unshift_origin_pkg::NUM_VTX;
    import unshift_origin_pkg::LAST_IDX;
    import unshift_origin_pkg::isLastVertex;
#(
    parameter logic [15:0] ORIGIN_X = unshift_origin_pkg::ORIGIN_X,
    parameter logic [15:0] ORIGIN_Y = unshift_origin_pkg::ORIGIN_Y,
    parameter logic [15:0] SCR_W    = unshift_origin_pkg::SCR_W,
    parameter logic [15:0] SCR_H    = unshift_origin_pkg::SCR_H
)(
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] vtx1_X,
    input  logic signed [15:0] vtx1_Y,
    input  logic signed [15:0] vtx1_Z,
    input  logic signed [15:0] vtx2_X,
    input  logic signed [15:0] vtx2_Y,
    input  logic signed [15:0] vtx2_Z,
    input  logic signed [15:0] vtx3_X,
    input  logic signed [15:0] vtx3_Y,
    input  logic signed [15:0] vtx3_Z,
    input  logic signed [15:0] vtx4_X,
    input  logic signed [15:0] vtx4_Y,
    input  logic signed [15:0] vtx4_Z,

    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_X,
    output logic signed [15:0] out_Y,
    output logic signed [15:0] out_Z,
    output logic [1:0]         out_idx,
    output logic               out_last,
    output logic               out_onscreen
);

    state_e  state_q;
    state_e  state_d;
    logic [1:0] idx_q;
    logic [1:0] idx_d;

    vertex_t quad_q [NUM_VTX];
    vertex_t inQuad [NUM_VTX];

    logic    captureQuad;
    vertex_t curVtx;
    vertex_t shiftVtx;
    logic    curOnscreen;

    assign inQuad[0] = {vtx1_X, vtx1_Y, vtx1_Z};
    assign inQuad[1] = {vtx2_X, vtx2_Y, vtx2_Z};
    assign inQuad[2] = {vtx3_X, vtx3_Y, vtx3_Z};
    assign inQuad[3] = {vtx4_X, vtx4_Y, vtx4_Z};

    // A quad is taken whenever both sides of the input handshake agree;
    // this covers both the idle case and the back-to-back case.
    assign captureQuad = in_valid && in_ready;

    // State register: FSM state and the index of the vertex on the output.
    // Reset drops any partially emitted quad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Quad storage: loaded only on an accepted input handshake so the
    // outputs stay frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VTX; i++) begin
                quad_q[i] <= '0;
            end
        end else if (captureQuad) begin
            for (int i = 0; i < NUM_VTX; i++) begin
                quad_q[i] <= inQuad[i];
            end
        end
    end

    // Next-state logic: walk idx 0..3 on each output handshake; after the
    // last vertex either restart on a waiting quad or fall back to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                idx_d = 2'd0;
                if (in_valid) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!isLastVertex(idx_q)) begin
                        idx_d = idx_q + 2'd1;
                    end else if (in_valid) begin
                        idx_d = 2'd0;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    assign curVtx = quad_q[idx_q];

    vtx_unshift #(
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y),
        .SCR_W    (SCR_W),
        .SCR_H    (SCR_H)
    ) u_vtx_unshift (
        .vtx_i      (curVtx),
        .vtx_o      (shiftVtx),
        .onscreen_o (curOnscreen)
    );

    // Output logic: the vertex outputs are forced to zero outside SEND so
    // that idle and reset present a clean all-zero bus. in_ready reaches
    // out_ready combinationally only on the last vertex, which is what
    // allows a new quad to follow without a gap.
    always_comb begin
        out_valid    = 1'b0;
        out_X        = '0;
        out_Y        = '0;
        out_Z        = '0;
        out_idx      = 2'd0;
        out_last     = 1'b0;
        out_onscreen = 1'b0;
        in_ready     = (state_q == IDLE);
        if (state_q == SEND) begin
            out_valid    = 1'b1;
            out_X        = shiftVtx.x;
            out_Y        = shiftVtx.y;
            out_Z        = shiftVtx.z;
            out_idx      = idx_q;
            out_last     = (idx_q == LAST_IDX);
            out_onscreen = curOnscreen;
            in_ready     = (idx_q == LAST_IDX) && out_ready;
        end
    end

endmodule
